// File: rtl/matrix_mopa_unit.sv
// rtl/matrix_mopa_unit.sv - outer-product accumulate engine for the 4x32 matrix register file
module matrix_mopa_unit #(
  parameter int XLEN   = 32,
  parameter int ELEM_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic                op_sat,
  input  logic                flush,
  input  logic [XLEN-1:0]     vec_a,
  input  logic [XLEN-1:0]     vec_b,
  input  logic [4*XLEN-1:0]   m_in,
  output logic                busy,
  output logic                done,
  output logic [4*XLEN-1:0]   w_matrix_data_mopa,
  output logic                w_matrix_en_mopa
);

  localparam int ROWS = XLEN / ELEM_W;
  localparam int SW   = 2 * ELEM_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (ELEM_W - 1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic                sub_q, sub_d, sat_q, sat_d;
  logic [4*XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]     row_cur, row_new;
  logic [ELEM_W-1:0]   a_cur;

  // One element: widen to 18 bits so a full 16-bit product never overflows before clamping.
  function automatic logic [ELEM_W-1:0] mac_elem(input logic [ELEM_W-1:0] m_e,
                                                 input logic [ELEM_W-1:0] a_e,
                                                 input logic [ELEM_W-1:0] b_e,
                                                 input logic sub, input logic sat);
    logic signed [2*ELEM_W-1:0] p;
    logic signed [SW-1:0]       m_x, p_x, s;
    logic [ELEM_W-1:0]          r;
    p   = $signed(a_e) * $signed(b_e);
    m_x = {{(SW-ELEM_W){m_e[ELEM_W-1]}}, m_e};
    p_x = {{2{p[2*ELEM_W-1]}}, p};
    s   = sub ? (m_x - p_x) : (m_x + p_x);
    r   = s[ELEM_W-1:0];
    if (sat && (s > SAT_MAX)) r = SAT_MAX[ELEM_W-1:0];
    if (sat && (s < SAT_MIN)) r = SAT_MIN[ELEM_W-1:0];
    return r;
  endfunction

  always_comb begin
    row_cur = buf_q[cnt_q*XLEN +: XLEN];
    a_cur   = a_q[cnt_q*ELEM_W +: ELEM_W];
    row_new = '0;
    for (int j = 0; j < ROWS; j++) begin
      row_new[j*ELEM_W +: ELEM_W] = mac_elem(row_cur[j*ELEM_W +: ELEM_W], a_cur,
                                             b_q[j*ELEM_W +: ELEM_W], sub_q, sat_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sat_d   = sat_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          a_d     = vec_a;
          b_d     = vec_b;
          sub_d   = op_sub;
          sat_d   = op_sat;
          buf_d   = m_in;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          buf_d[cnt_q*XLEN +: XLEN] = row_new;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(ROWS - 1)) state_d = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sat_q   <= sat_d;
      buf_q   <= buf_d;
    end
  end

  // Flush must kill the strobe in the same cycle, so the commit decode is gated combinationally.
  assign busy               = (state_q != IDLE);
  assign w_matrix_en_mopa   = (state_q == WRITE) && !flush;
  assign done               = (state_q == WRITE) && !flush;
  assign w_matrix_data_mopa = buf_q;

endmodule

// File: tb/tb_matrix_mopa_unit.sv
// tb/tb_matrix_mopa_unit.sv - self-checking bench for matrix_mopa_unit
module tb_matrix_mopa_unit;

  logic         clk = 1'b0;
  logic         rst, start, op_sub, op_sat, flush;
  logic [31:0]  vec_a, vec_b;
  logic [127:0] m_in;
  logic         busy, done, w_matrix_en_mopa;
  logic [127:0] w_matrix_data_mopa;

  int errors = 0;
  int checks = 0;

  matrix_mopa_unit dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .op_sat(op_sat),
    .flush(flush), .vec_a(vec_a), .vec_b(vec_b), .m_in(m_in),
    .busy(busy), .done(done), .w_matrix_data_mopa(w_matrix_data_mopa),
    .w_matrix_en_mopa(w_matrix_en_mopa)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] m;
    logic [31:0]  a;
    logic [31:0]  b;
    logic         sub;
    logic         sat;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[6];

  // Reference: M[i][j] +/- a[i]*b[j] with plain integer arithmetic.
  function automatic logic [127:0] model(input logic [127:0] m, input logic [31:0] a,
                                         input logic [31:0] b, input logic sub, input logic sat);
    logic [127:0] r;
    logic [7:0]   me, ae, be;
    int           mi, ai, bi, s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        me = m[32*i + 8*j +: 8];
        ae = a[8*i +: 8];
        be = b[8*j +: 8];
        mi = $signed(me);
        ai = $signed(ae);
        bi = $signed(be);
        s  = sub ? (mi - ai * bi) : (mi + ai * bi);
        if (sat && s > 127)  s = 127;
        if (sat && s < -128) s = -128;
        r[32*i + 8*j +: 8] = s[7:0];
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered in "cycle 0" (just after an edge, DUT idle); leaves in cycle 6.
  task automatic run(input string tag, input logic [127:0] m, input logic [31:0] a,
                     input logic [31:0] b, input logic sub, input logic sat,
                     input logic [127:0] exp, input int restart_c, input int flush_c);
    logic commit;
    int   last_busy;
    commit    = !(flush_c >= 1 && flush_c <= 5);
    last_busy = commit ? 5 : flush_c;
    m_in = m; vec_a = a; vec_b = b; op_sub = sub; op_sat = sat;
    start = 1'b1; flush = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      start = (k == restart_c);
      flush = (k == flush_c);
      #1;
      chk($sformatf("%s c%0d busy", tag, k), 128'(busy), 128'(k <= last_busy));
      chk($sformatf("%s c%0d en", tag, k), 128'(w_matrix_en_mopa), 128'(commit && k == 5));
      chk($sformatf("%s c%0d done", tag, k), 128'(done), 128'(commit && k == 5));
      if (commit && k == 5) chk($sformatf("%s data", tag), w_matrix_data_mopa, exp);
    end
    start = 1'b0; flush = 1'b0;
  endtask

  logic [127:0] basic_m, basic_exp, r_m, r_exp;
  logic [31:0]  r_a, r_b;
  logic         r_sub, r_sat;

  initial begin
    rst = 1'b0; start = 1'b1; flush = 1'b0; op_sub = 1'b0; op_sat = 1'b0;
    vec_a = 32'h04030201; vec_b = 32'h01010101; m_in = '0;

    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst%0d busy", k), 128'(busy), 128'(0));
      chk($sformatf("rst%0d done", k), 128'(done), 128'(0));
      chk($sformatf("rst%0d en", k), 128'(w_matrix_en_mopa), 128'(0));
      chk($sformatf("rst%0d data", k), w_matrix_data_mopa, 128'(0));
    end
    rst = 1'b1; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d busy", k), 128'(busy), 128'(0));
      chk($sformatf("idle%0d en", k), 128'(w_matrix_en_mopa), 128'(0));
    end

    basic_m   = '0;
    basic_exp = {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    tbl[0] = '{basic_m, 32'h04030201, 32'h01010101, 1'b0, 1'b0, basic_exp};
    tbl[1] = '{basic_exp, 32'h04030201, 32'h01010101, 1'b0, 1'b0,
               {32'h08080808, 32'h06060606, 32'h04040404, 32'h02020202}};
    tbl[2] = '{{32'h55555555, 32'h55555555, 32'h55555555, 32'h000000FF},
               32'h00000001, 32'h00000001, 1'b0, 1'b0,
               {32'h55555555, 32'h55555555, 32'h55555555, 32'h00000000}};
    tbl[3] = '{{96'h0, 32'h0000007F}, 32'h00000010, 32'h00000010, 1'b0, 1'b1,
               {96'h0, 32'h0000007F}};
    tbl[4] = '{{96'h0, 32'h00000080}, 32'h00000001, 32'h00000001, 1'b1, 1'b1,
               {96'h0, 32'h00000080}};
    tbl[5] = '{{96'h0, 32'h00000080}, 32'h00000001, 32'h00000001, 1'b1, 1'b0,
               {96'h0, 32'h0000007F}};

    // Runs are back to back: each starts in the cycle the previous one returns to idle.
    for (int t = 0; t < 6; t++)
      run($sformatf("tbl%0d", t), tbl[t].m, tbl[t].a, tbl[t].b, tbl[t].sub, tbl[t].sat,
          tbl[t].exp, 0, 0);

    run("restart", basic_m, 32'h04030201, 32'h01010101, 1'b0, 1'b0, basic_exp, 2, 0);
    run("flush_calc", basic_m, 32'h04030201, 32'h01010101, 1'b0, 1'b0, basic_exp, 0, 3);
    run("flush_write", basic_m, 32'h04030201, 32'h01010101, 1'b0, 1'b0, basic_exp, 0, 5);
    run("after_flush", basic_m, 32'h04030201, 32'h01010101, 1'b0, 1'b0, basic_exp, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r_m   = {$urandom, $urandom, $urandom, $urandom};
      r_a   = $urandom;
      r_b   = $urandom;
      r_sub = 1'($urandom_range(0, 1));
      r_sat = 1'($urandom_range(0, 1));
      r_exp = model(r_m, r_a, r_b, r_sub, r_sat);
      run($sformatf("rnd%0d", n), r_m, r_a, r_b, r_sub, r_sat, r_exp, 0, 0);
    end

    // Reset in the middle of a calculation abandons it without a commit.
    m_in = {4{32'h11223344}}; vec_a = 32'h01020304; vec_b = 32'h05060708;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst busy", 128'(busy), 128'(0));
    chk("midrst data", w_matrix_data_mopa, 128'(0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst c%0d en", k), 128'(w_matrix_en_mopa), 128'(0));
      chk($sformatf("midrst c%0d busy", k), 128'(busy), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
